// File: rtl/s2p_frame_ctrl.sv
// s2p_frame_ctrl
// Frame controller for the serial-to-parallel deserializer. It enables the
// deserializer, collects TOTAL_DATA consecutive words into a word buffer,
// then drains the whole frame to a downstream consumer over valid/ready.
//
// Ports
//   clk            : clock, all state on the rising edge
//   rst            : asynchronous active-high reset
//   start          : request to capture one frame (honoured only in IDLE)
//   abort          : cancel the frame in progress (highest priority)
//   s2p_enable     : enable to the deserializer (high while capturing)
//   s2p_data       : deserializer parallel word
//   s2p_data_valid : s2p_data valid this cycle
//   out_data       : buffer word at the read pointer
//   out_valid      : out_data valid (high while draining)
//   out_ready      : consumer accepts out_data
//   out_last       : out_data is the final word of the frame
//   frame_done     : one-cycle pulse after the final handshake
//   aborted        : one-cycle pulse after an abort is taken
//   overrun        : sticky, a valid word arrived while not capturing
//   frame_count    : completed frames, wraps 255 -> 0
module s2p_frame_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 3,
  parameter int TOTAL_DATA    = 2**ADDRESS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  s2p_enable,
  input  logic [DATA_WIDTH-1:0] s2p_data,
  input  logic                  s2p_data_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  aborted,
  output logic                  overrun,
  output logic [7:0]            frame_count
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(TOTAL_DATA - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
  logic [DATA_WIDTH-1:0]    r_buf [TOTAL_DATA];
  logic                     r_frame_done;
  logic                     r_aborted;
  logic                     r_overrun;
  logic [7:0]               r_frame_count;

  logic w_start_ok;
  logic w_cap_wr;
  logic w_cap_last;
  logic w_drain_hs;
  logic w_drain_last;
  logic w_abort_ok;

  // abort only acts on an active frame; in IDLE it merely masks start
  assign w_abort_ok   = abort && (r_state != IDLE);
  assign w_start_ok   = (r_state == IDLE) && start && !abort;
  assign w_cap_wr     = (r_state == CAPTURE) && s2p_data_valid && !abort;
  assign w_cap_last   = w_cap_wr && (r_wr_ptr == LAST_IDX);
  assign w_drain_hs   = (r_state == DRAIN) && out_ready && !abort;
  assign w_drain_last = w_drain_hs && (r_rd_ptr == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok)   w_next = CAPTURE;
      CAPTURE: if (w_abort_ok)   w_next = IDLE;
               else if (w_cap_last) w_next = DRAIN;
      DRAIN:   if (w_abort_ok)   w_next = IDLE;
               else if (w_drain_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_frame_done  <= 1'b0;
      r_aborted     <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
      for (int i = 0; i < TOTAL_DATA; i++) r_buf[i] <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_aborted    <= 1'b0;

      // stray words outside CAPTURE are dropped but remembered
      if (s2p_data_valid && (r_state != CAPTURE)) r_overrun <= 1'b1;

      // an accepted start opens a fresh frame and clears the overrun flag
      if (w_start_ok) begin
        r_wr_ptr  <= '0;
        r_overrun <= 1'b0;
      end

      if (w_abort_ok) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_aborted <= 1'b1;
      end

      if (w_cap_wr) begin
        r_buf[r_wr_ptr] <= s2p_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        if (w_cap_last) r_rd_ptr <= '0;
      end

      if (w_drain_hs) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_drain_last) begin
          r_frame_done  <= 1'b1;
          r_frame_count <= r_frame_count + 8'd1;
        end
      end
    end
  end

  // outputs decode registered state only; no input reaches them combinationally
  assign s2p_enable  = (r_state == CAPTURE);
  assign out_valid   = (r_state == DRAIN);
  assign out_data    = r_buf[r_rd_ptr];
  assign out_last    = (r_state == DRAIN) && (r_rd_ptr == LAST_IDX);
  assign frame_done  = r_frame_done;
  assign aborted     = r_aborted;
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
module tb_s2p_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        s2p_enable;
  logic [63:0] s2p_data = '0;
  logic        s2p_data_valid = 1'b0;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        frame_done;
  logic        aborted;
  logic        overrun;
  logic [7:0]  frame_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_count = 0;

  s2p_frame_ctrl #(.DATA_WIDTH(64), .ADDRESS_WIDTH(3), .TOTAL_DATA(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s2p_enable(s2p_enable), .s2p_data(s2p_data), .s2p_data_valid(s2p_data_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_done(frame_done), .aborted(aborted),
    .overrun(overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Stimulus drivers: every task starts and ends just after a falling edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_words(input logic [63:0] base);
    for (int i = 0; i < 8; i++) begin
      s2p_data_valid = 1'b1;
      s2p_data = base + 64'(i);
      @(negedge clk);
    end
    s2p_data_valid = 1'b0;
  endtask

  task automatic drain_all();
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (s2p_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %0b want 0", s2p_enable); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_data !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_vec++; if ({out_last, frame_done, aborted, overrun} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {out_last, frame_done, aborted, overrun}); end
    n_vec++; if (frame_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", frame_count); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (s2p_enable !== 1'b0) begin n_err++; $display("FAIL reset_idle: got %0b want 0", s2p_enable); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    do_start();
    n_vec++; if (s2p_enable !== 1'b1) begin n_err++; $display("FAIL basic_enable: got %0b want 1", s2p_enable); end
    for (int i = 0; i < 8; i++) begin
      s2p_data_valid = 1'b1;
      s2p_data = 64'(i + 1);
      @(negedge clk);
    end
    s2p_data_valid = 1'b0;
    n_vec++; if (s2p_enable !== 1'b0) begin n_err++; $display("FAIL basic_enable_off: got %0b want 0", s2p_enable); end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d]: got %0b want 1", i, out_valid); end
      n_vec++; if (out_data !== 64'(i + 1)) begin n_err++; $display("FAIL basic_data[%0d]: got %h want %h", i, out_data, 64'(i + 1)); end
      n_vec++; if (out_last !== (i == 7)) begin n_err++; $display("FAIL basic_last[%0d]: got %0b want %0b", i, out_last, (i == 7)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    exp_count++;
    n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %0b want 1", frame_done); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_off: got %0b want 0", out_valid); end
    n_vec++; if (frame_count !== 8'(exp_count)) begin n_err++; $display("FAIL basic_count: got %0d want %0d", frame_count, exp_count); end
    @(negedge clk);
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %0b want 0", frame_done); end
  endtask

  task automatic test_backpressure();
    int k;
    int cyc;
    logic rdy;
    do_start();
    send_words(64'h100);
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 40) begin
      rdy = (cyc % 3 == 0);
      out_ready = rdy;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %0b want 1", cyc, out_valid); end
      n_vec++; if (out_data !== 64'h100 + 64'(k)) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", cyc, out_data, 64'h100 + 64'(k)); end
      n_vec++; if (out_last !== (k == 7)) begin n_err++; $display("FAIL bp_last[%0d]: got %0b want %0b", cyc, out_last, (k == 7)); end
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    out_ready = 1'b0;
    exp_count++;
    n_vec++; if (k !== 8 || cyc !== 22) begin n_err++; $display("FAIL bp_handshakes: got %0d in %0d cycles want 8 in 22", k, cyc); end
    n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL bp_done: got %0b want 1", frame_done); end
    // start in the frame_done cycle must be taken
    do_start();
    n_vec++; if (s2p_enable !== 1'b1) begin n_err++; $display("FAIL b2b_enable: got %0b want 1", s2p_enable); end
    send_words(64'h200);
    n_vec++; if (out_data !== 64'h200) begin n_err++; $display("FAIL b2b_data: got %h want 200", out_data); end
    drain_all();
    exp_count++;
    n_vec++; if (frame_count !== 8'(exp_count)) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_gapped();
    do_start();
    for (int i = 0; i < 8; i++) begin
      s2p_data_valid = 1'b1;
      s2p_data = 64'h10 + 64'(i);
      @(negedge clk);
      s2p_data_valid = 1'b0;
      if (i < 7) begin
        n_vec++; if (out_valid !== 1'b0 || s2p_enable !== 1'b1) begin n_err++; $display("FAIL gap_capture[%0d]: got valid=%0b en=%0b want 0/1", i, out_valid, s2p_enable); end
        repeat (2) @(negedge clk);
      end
    end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL gap_latency: got %0b want 1", out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (out_data !== 64'h10 + 64'(i)) begin n_err++; $display("FAIL gap_data[%0d]: got %h want %h", i, out_data, 64'h10 + 64'(i)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    exp_count++;
    n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL gap_done: got %0b want 1", frame_done); end
  endtask

  task automatic test_abort();
    do_start();
    for (int i = 0; i < 5; i++) begin
      s2p_data_valid = 1'b1;
      s2p_data = 64'h50 + 64'(i);
      @(negedge clk);
    end
    s2p_data_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++; if (aborted !== 1'b1) begin n_err++; $display("FAIL abort_pulse: got %0b want 1", aborted); end
    n_vec++; if (s2p_enable !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL abort_idle: got en=%0b valid=%0b want 0/0", s2p_enable, out_valid); end
    n_vec++; if (frame_count !== 8'(exp_count)) begin n_err++; $display("FAIL abort_count: got %0d want %0d", frame_count, exp_count); end
    @(negedge clk);
    n_vec++; if (aborted !== 1'b0) begin n_err++; $display("FAIL abort_pulse_end: got %0b want 0", aborted); end
    // abort in IDLE: no pulse, and it masks start
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_vec++; if (s2p_enable !== 1'b0 || aborted !== 1'b0) begin n_err++; $display("FAIL abort_idle_start: got en=%0b ab=%0b want 0/0", s2p_enable, aborted); end
    do_start();
    send_words(64'hA0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (out_data !== 64'hA0 + 64'(i)) begin n_err++; $display("FAIL abort_next_data[%0d]: got %h want %h", i, out_data, 64'hA0 + 64'(i)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    exp_count++;
    n_vec++; if (frame_count !== 8'(exp_count)) begin n_err++; $display("FAIL abort_next_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_overrun();
    s2p_data_valid = 1'b1;
    s2p_data = 64'hDEAD;
    @(negedge clk);
    s2p_data_valid = 1'b0;
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %0b want 1", overrun); end
    n_vec++; if (out_data !== 64'hA0) begin n_err++; $display("FAIL ovr_no_write: got %h want a0", out_data); end
    do_start();
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %0b want 0", overrun); end
    send_words(64'h80);
    start = 1'b1;
    s2p_data_valid = 1'b1;
    s2p_data = 64'hBEEF;
    @(negedge clk);
    start = 1'b0;
    s2p_data_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || s2p_enable !== 1'b0) begin n_err++; $display("FAIL drain_start_ignored: got valid=%0b en=%0b want 1/0", out_valid, s2p_enable); end
    n_vec++; if (out_data !== 64'h80) begin n_err++; $display("FAIL drain_stall_data: got %h want 80", out_data); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_drain: got %0b want 1", overrun); end
    drain_all();
    exp_count++;
    n_vec++; if (frame_done !== 1'b1 || s2p_enable !== 1'b0) begin n_err++; $display("FAIL ovr_frame_end: got done=%0b en=%0b want 1/0", frame_done, s2p_enable); end
    @(negedge clk);
    n_vec++; if (s2p_enable !== 1'b0 || overrun !== 1'b1) begin n_err++; $display("FAIL start_not_queued: got en=%0b ovr=%0b want 0/1", s2p_enable, overrun); end
    do_start();
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear2: got %0b want 0", overrun); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset_and_wrap();
    do_start();
    for (int i = 0; i < 3; i++) begin
      s2p_data_valid = 1'b1;
      s2p_data = 64'h30 + 64'(i);
      @(negedge clk);
    end
    s2p_data_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (s2p_enable !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin n_err++; $display("FAIL async_rst_ctrl: got en=%0b valid=%0b last=%0b want 0", s2p_enable, out_valid, out_last); end
    n_vec++; if (out_data !== 64'h0) begin n_err++; $display("FAIL async_rst_data: got %h want 0", out_data); end
    n_vec++; if (frame_count !== 8'd0 || {frame_done, aborted, overrun} !== 3'b0) begin n_err++; $display("FAIL async_rst_status: got cnt=%0d flags=%b want 0", frame_count, {frame_done, aborted, overrun}); end
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    for (int f = 0; f < 255; f++) begin
      do_start();
      send_words(64'(f) << 8);
      drain_all();
    end
    n_vec++; if (frame_count !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d want 255", frame_count); end
    do_start();
    send_words(64'h900);
    drain_all();
    n_vec++; if (frame_count !== 8'd0 || frame_done !== 1'b1) begin n_err++; $display("FAIL wrap_0: got cnt=%0d done=%0b want 0/1", frame_count, frame_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_abort();
    test_overrun();
    test_reset_and_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
